// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient loader.
// Frame format, state encoding and error codes.
package fir_pkg;

  localparam int N_TAPS = 16;
  localparam int COEF_W = 12;
  localparam int IDX_W = $clog2(N_TAPS);
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_LO   = 3'd1,
    ST_RX_HI   = 3'd2,
    ST_RX_CSUM = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_FLUSH   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient banks.
// Shadow is written per tap; commit copies it to the active bank.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [COEF_W-1:0]          wr_data_i,
  input  logic                       commit_i,
  output logic [N_TAPS*COEF_W-1:0]   coef_o
);

  logic [COEF_W-1:0] shd_q [N_TAPS];
  logic [COEF_W-1:0] act_q [N_TAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      if (wr_en_i)
        shd_q[wr_idx_i] <= wr_data_i;
      if (commit_i)
        for (int k = 0; k < N_TAPS; k++)
          act_q[k] <= shd_q[k];
    end
  end

  for (genvar k = 0; k < N_TAPS; k++) begin : g_flat
    assign coef_o[k*COEF_W +: COEF_W] = act_q[k];
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Framed coefficient loader: header, 16 x {lo, hi} bytes, XOR checksum.
// Commits on a good frame and gates the FIR enable around the commit.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk_78MHz,
  input  logic                      rst,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  input  logic                      run_i,
  output logic [N_TAPS*COEF_W-1:0]  coef_o,
  output logic                      en_fir_o,
  output logic                      busy_o,
  output logic                      load_done_o,
  output logic                      coef_valid_o,
  output logic [1:0]                err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [1:0]        err_q, err_d;
  logic              ld_q, ld_d;
  logic              cv_q, cv_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              wr_en;
  logic              commit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    ld_d    = 1'b0;
    cv_d    = cv_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && rx_data_i == HDR_BYTE) begin
          state_d = ST_RX_LO;
          err_d   = ERR_NONE;
          csum_d  = '0;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      ST_RX_LO: begin
        if (rx_valid_i) begin
          lo_d    = rx_data_i;
          csum_d  = csum_q ^ rx_data_i;
          tmr_d   = '0;
          state_d = ST_RX_HI;
        end
      end
      ST_RX_HI: begin
        if (rx_valid_i) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ rx_data_i;
          tmr_d  = '0;
          if (idx_q == IDX_W'(N_TAPS - 1)) begin
            state_d = ST_RX_CSUM;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RX_LO;
          end
        end
      end
      ST_RX_CSUM: begin
        if (rx_valid_i) begin
          tmr_d = '0;
          if (rx_data_i == csum_q) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = ERR_CSUM;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        ld_d    = 1'b1;
        cv_d    = 1'b1;
        state_d = ST_FLUSH;
        if (rx_valid_i) err_d = ERR_OVR;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        if (rx_valid_i) err_d = ERR_OVR;
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte watchdog; it is the only way out of a misframed stream
    if (!rx_valid_i && state_q inside {ST_RX_LO, ST_RX_HI, ST_RX_CSUM}) begin
      if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d   = ERR_TMO;
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    en_d   = run_i && cv_d && !(state_d inside {ST_COMMIT, ST_FLUSH});
    busy_d = state_d inside {ST_RX_LO, ST_RX_HI, ST_RX_CSUM, ST_COMMIT};
  end

  always_ff @(posedge clk_78MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      tmr_q   <= '0;
      err_q   <= ERR_NONE;
      ld_q    <= 1'b0;
      cv_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      cv_q    <= cv_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  fir_coef_bank u_bank (
    .clk       (clk_78MHz),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i ({rx_data_i[3:0], lo_q}),
    .commit_i  (commit),
    .coef_o    (coef_o)
  );

  assign en_fir_o     = en_q;
  assign busy_o       = busy_q;
  assign load_done_o  = ld_q;
  assign coef_valid_o = cv_q;
  assign err_o        = err_q;

endmodule
